// File: rtl/io_btn_event.sv
// io_btn_event: four debounced push-buttons queued as 3-bit press/release events, drained over the I/O bus.
// Define IO_BTN_IRQ_EN to drive irq as a registered FIFO-not-empty flag and advertise it in STATUS[12].
module io_btn_event #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int FIFO_DEPTH      = 8
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic [31:0] A,
   input  logic [31:0] WD,
   input  logic        WE,
   input  logic        MREQ,
   input  logic [3:0]  BTN,
   output logic [31:0] IO_Data,
   output logic        irq
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   logic [3:0]    r_sync1, r_sync2, r_stable, r_press_pend, r_rel_pend;
   logic [15:0]   r_cnt [4];
   logic [2:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_ovf;
   logic          w_rd_data, w_rd_stat, w_wr_stat, w_empty, w_full, w_pop, w_push, w_flush, w_ovf_set, w_irq_cap;
   logic [3:0]    w_acc, w_clr_p, w_clr_r;
   logic [7:0]    w_pend, w_grant;
   logic [2:0]    w_code;
   logic [31:0]   w_status;
   logic          w_unused;

   assign w_rd_data = MREQ & (A == 32'hFFFF_FFF4) & ~WE;
   assign w_rd_stat = MREQ & (A == 32'hFFFF_FFFC) & ~WE;
   assign w_wr_stat = MREQ & (A == 32'hFFFF_FFFC) & WE;
   assign w_unused  = ^{WD[31:8], WD[5:0]};

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == FULL_CNT);
   assign w_pop   = w_rd_data & ~w_empty;
   assign w_flush = w_wr_stat & WD[7];

   // presses occupy the low half so the lowest set bit gives press-first, low-index-first order
   assign w_pend  = {r_rel_pend, r_press_pend};
   assign w_grant = w_pend & (~w_pend + 8'd1);
   assign w_push  = (|w_pend) & (~w_full | w_pop) & ~w_flush;
   assign w_clr_p = w_push ? w_grant[3:0] : 4'b0;
   assign w_clr_r = w_push ? w_grant[7:4] : 4'b0;

   always_comb begin
      w_code = '0;
      for (int j = 0; j < 8; j++)
         if (w_grant[j]) w_code = 3'(j) ^ 3'b100;
   end

   always_comb begin
      for (int i = 0; i < 4; i++)
         w_acc[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == DB_LAST);
   end

   assign w_ovf_set = |((w_acc & r_sync2 & r_press_pend & ~w_clr_p) |
                        (w_acc & ~r_sync2 & r_rel_pend & ~w_clr_r));

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_sync1      <= '0;
         r_sync2      <= '0;
         r_stable     <= '0;
         r_press_pend <= '0;
         r_rel_pend   <= '0;
         r_ovf        <= 1'b0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
      end else begin
         r_sync1 <= BTN;
         r_sync2 <= r_sync1;
         for (int i = 0; i < 4; i++)
            r_cnt[i] <= (r_sync2[i] == r_stable[i] || w_acc[i]) ? 16'd0 : r_cnt[i] + 16'd1;
         r_stable     <= r_stable ^ w_acc;
         r_press_pend <= (r_press_pend & ~w_clr_p) | (w_acc & r_sync2);
         r_rel_pend   <= (r_rel_pend & ~w_clr_r) | (w_acc & ~r_sync2);
         r_ovf        <= (r_ovf & ~(w_wr_stat & WD[6])) | w_ovf_set;
         if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_code;
   end

   assign w_status = {19'b0, w_irq_cap, r_stable, 1'b0, r_ovf, w_full, w_empty, 4'(r_count)};
   assign IO_Data  = w_rd_data ? (w_empty ? 32'h0 : {1'b1, 28'b0, r_mem[r_rd_ptr]}) :
                     w_rd_stat ? w_status : 32'h0;

`ifdef IO_BTN_IRQ_EN
   assign w_irq_cap = 1'b1;
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) irq <= 1'b0;
      else irq <= ~w_empty;
   end
`else
   assign w_irq_cap = 1'b0;
   assign irq       = 1'b0;
`endif
endmodule

// File: tb/tb_io_btn_event.sv
// tb_io_btn_event: directed scenarios plus random buttons/bus traffic against an event-level reference model.
module tb_io_btn_event;
   localparam int D = 4;
   localparam int N = 4;
   localparam logic [31:0] ADDR_DATA = 32'hFFFF_FFF4;
   localparam logic [31:0] ADDR_STAT = 32'hFFFF_FFFC;
`ifdef IO_BTN_IRQ_EN
   localparam logic CAP = 1'b1;
`else
   localparam logic CAP = 1'b0;
`endif
   localparam logic [31:0] C = CAP ? 32'h1000 : 32'h0;

   logic        clk = 1'b0, nrst = 1'b0, WE = 1'b0, MREQ = 1'b0, irq;
   logic [31:0] A = '0, WD = '0, IO_Data;
   logic [3:0]  BTN = '0;

   io_btn_event #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(N)) dut (
      .clk(clk), .nrst(nrst), .A(A), .WD(WD), .WE(WE), .MREQ(MREQ),
      .BTN(BTN), .IO_Data(IO_Data), .irq(irq)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // reference model: raw level seen two cycles late; a level held D cycles becomes stable
   bit       m_s1 [4], m_s2 [4], m_st [4];
   int       m_run [4];
   bit       m_pend [8];
   bit [2:0] m_q [$];
   bit       m_ovf, m_irq;

   task automatic m_reset();
      for (int i = 0; i < 4; i++) begin
         m_s1[i] = 0; m_s2[i] = 0; m_st[i] = 0; m_run[i] = 0;
      end
      for (int j = 0; j < 8; j++) m_pend[j] = 0;
      m_q.delete();
      m_ovf = 0;
      m_irq = 0;
   endtask

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s = 32'(m_q.size());
      if (m_q.size() == 0) s |= 32'h10;
      if (m_q.size() == N) s |= 32'h20;
      if (m_ovf) s |= 32'h40;
      for (int i = 0; i < 4; i++) if (m_st[i]) s |= 32'h100 << i;
      return s | C;
   endfunction

   function automatic logic [31:0] m_read();
      if (!MREQ || WE) return 32'h0;
      if (A == ADDR_DATA) return m_q.size() > 0 ? (32'h8000_0000 | 32'(m_q[0])) : 32'h0;
      if (A == ADDR_STAT) return m_status();
      return 32'h0;
   endfunction

   task automatic m_step();
      int  jp = -1;
      bit  pop, flush, clr, push, oset;
      for (int j = 0; j < 8; j++) if (m_pend[j] && jp < 0) jp = j;
      pop   = MREQ && !WE && A == ADDR_DATA && m_q.size() > 0;
      flush = MREQ && WE && A == ADDR_STAT && WD[7];
      clr   = MREQ && WE && A == ADDR_STAT && WD[6];
      push  = jp >= 0 && (m_q.size() < N || pop) && !flush;
      oset  = 0;
      m_irq = m_q.size() > 0;
      if (pop) void'(m_q.pop_front());
      if (flush) m_q.delete();
      if (push) begin
         m_q.push_back(jp < 4 ? 3'(4 + jp) : 3'(jp - 4));
         m_pend[jp] = 0;
      end
      for (int i = 0; i < 4; i++) begin
         if (m_s2[i] != m_st[i]) begin
            m_run[i]++;
            if (m_run[i] == D) begin
               int k;
               m_st[i]  = m_s2[i];
               m_run[i] = 0;
               k = m_st[i] ? i : 4 + i;
               if (m_pend[k]) oset = 1;
               else m_pend[k] = 1;
            end
         end else m_run[i] = 0;
         m_s2[i] = m_s1[i];
         m_s1[i] = BTN[i];
      end
      m_ovf = (m_ovf && !clr) || oset;
   endtask

   task automatic tick();
      #1 chk("io_data", IO_Data, m_read());
      m_step();
      @(posedge clk);
      #1 chk("irq", {31'b0, irq}, CAP ? {31'b0, m_irq} : 32'h0);
      @(negedge clk);
   endtask

   task automatic bus(input logic m, input logic w, input logic [31:0] a, input logic [31:0] d);
      MREQ = m; WE = w; A = a; WD = d;
   endtask

   task automatic idle(input int n);
      bus(0, 0, 0, 0);
      repeat (n) tick();
   endtask

   task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
      bus(1, 0, a, 0);
      #1 chk(tag, IO_Data, exp);
      tick();
      bus(0, 0, 0, 0);
   endtask

   task automatic wr_stat(input logic [31:0] d);
      bus(1, 1, ADDR_STAT, d);
      tick();
      bus(0, 0, 0, 0);
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      bus(1, 0, ADDR_STAT, 0);
      #1 chk("rst_irq", {31'b0, irq}, 32'h0);
      chk("rst_stat", IO_Data, 32'h10 | C);
      m_reset();
      @(posedge clk);
      @(negedge clk);
      nrst = 1'b1;
      bus(0, 0, 0, 0);
   endtask

   initial begin
      int hold [4];
      m_reset();
      repeat (2) @(negedge clk);
      nrst = 1'b1;

      rd(ADDR_STAT, "st_reset", 32'h10 | C);
      rd(ADDR_DATA, "data_empty", 32'h0);

      BTN[2] = 1'b1; idle(10);
      rd(ADDR_DATA, "press2", 32'h8000_0006);
      rd(ADDR_DATA, "empty_again", 32'h0);
      BTN[2] = 1'b0; idle(10);
      rd(ADDR_DATA, "rel2", 32'h8000_0002);

      BTN[1] = 1'b1; idle(3);
      BTN[1] = 1'b0; idle(10);
      rd(ADDR_STAT, "glitch", 32'h10 | C);

      BTN = 4'hF; idle(10);
      rd(ADDR_STAT, "full", 32'h0F24 | C);

      BTN = 4'h0; idle(10);
      BTN = 4'h1; idle(10);
      BTN = 4'h0; idle(10);
      BTN = 4'h1; idle(10);
      rd(ADDR_STAT, "ovf", 32'h0164 | C);
      wr_stat(32'hC0);
      rd(ADDR_STAT, "flushed", 32'h0110 | C);
      rd(ADDR_DATA, "drain_p0", 32'h8000_0004);
      for (int i = 0; i < 4; i++) rd(ADDR_DATA, "drain_rel", 32'h8000_0000 | 32'(i));

      BTN = 4'h3; idle(10);
      chk("irq_up", {31'b0, irq}, {31'b0, CAP});
      rd(ADDR_DATA, "press1", 32'h8000_0005);
      idle(1);
      chk("irq_down", {31'b0, irq}, 32'h0);

      BTN = 4'h0; idle(10);
      wr_stat(32'h80);
      BTN = 4'h8; idle(4);
      BTN = 4'h0;
      do_reset();
      idle(10);
      rd(ADDR_STAT, "rst_mid", 32'h10 | C);

      for (int i = 0; i < 4; i++) hold[i] = 0;
      for (int n = 0; n < 3000; n++) begin
         int r;
         for (int i = 0; i < 4; i++) begin
            if (hold[i] == 0) begin
               BTN[i]  = 1'($urandom_range(0, 1));
               hold[i] = $urandom_range(1, 12);
            end else hold[i]--;
         end
         r = $urandom_range(0, (n / 500) % 2 ? 40 : 15);
         if (r < 4) bus(1, 0, ADDR_DATA, 0);
         else if (r < 6) bus(1, 0, ADDR_STAT, 0);
         else if (r == 6) bus(1, 1, ADDR_STAT, $urandom_range(0, 3) == 0 ? $urandom : ($urandom & ~32'hC0));
         else if (r == 7) bus(1, 1, ADDR_DATA, $urandom);
         else if (r == 8) bus(1, 1'($urandom_range(0, 1)), $urandom, $urandom);
         else bus(0, 0, 0, 0);
         if ($urandom_range(0, 999) == 0) do_reset();
         else tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/io_btn_event.md
# io_btn_event

Memory-mapped push-button input peripheral for the RISC-V I/O space, complementing the write-only seven-segment output path. It synchronises and debounces four raw buttons, turns each debounced press or release into an event code, and queues the codes in a small FIFO. The CPU drains the FIFO with loads on the shared data bus. `IO_Data` is zero whenever the block is not selected, so it can be OR-combined with the other I/O read buses.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: number of consecutive stable cycles required to accept a new level. Range 1..65535, counter is 16 bits.
- `FIFO_DEPTH`, default 8: number of event entries. Must be a power of 2, in the range 2..8.
- `clk` input, 1 bit: system clock, all state updates on the rising edge.
- `nrst` input, 1 bit: asynchronous, active-low reset.
- `A` input, 32 bits: bus address.
- `WD` input, 32 bits: bus write data.
- `WE` input, 1 bit: 1 = store, 0 = load.
- `MREQ` input, 1 bit: memory/IO request qualifier.
- `BTN` input, 4 bits: raw buttons, active-high, asynchronous to `clk`.
- `IO_Data` output, 32 bits: read data, zero when not selected.
- `irq` output, 1 bit: FIFO-not-empty interrupt. Tied to 0 unless `IO_BTN_IRQ_EN` is defined.

## Operation
- Decoded accesses:
  - `sel_data` = MREQ & (A == 32'hFFFF_FFF4).
  - `sel_stat` = MREQ & (A == 32'hFFFF_FFFC).
  - A read is `sel & ~WE`; a write is `sel & WE`.
- Per-button input path:
  - Two-flop synchroniser, reset value 0.
  - 16-bit debounce counter, reset value 0. It increments while the synchronised input differs from `stable[i]` and clears while they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the input still differs, `stable[i]` takes the synchronised value and the counter clears.
  - A 0→1 change of `stable[i]` sets `press_pend[i]`; a 1→0 change sets `rel_pend[i]`.
- Event code is 3 bits: [2] is 1 for a press and 0 for a release; [1:0] is the button index.
- Arbiter:
  - Pushes at most one pending event per cycle.
  - Priority: all press events before any release event; within each kind, the lowest index goes first.
  - A pending bit clears on the edge at which its event is pushed.
- Push is allowed when the FIFO is not full, or when a pop happens in the same cycle.
- Overflow: if a new edge arrives while the same pending bit is already set, `ovf` is set (sticky). The pending bit stays set and the extra event is lost.
- DATA read:
  - Returns {1'b1, 28'b0, head[2:0]} if the FIFO is non-empty, otherwise 32'h0.
  - Pops the head on the same clock edge.
  - Reading DATA while the FIFO is empty has no effect.
- STATUS read returns:
  - [3:0] count (0..FIFO_DEPTH)
  - [4] empty
  - [5] full
  - [6] ovf
  - [11:8] `stable[3:0]`
  - all other bits 0
- STATUS write:
  - WD[6]=1 clears `ovf`.
  - WD[7]=1 flushes the FIFO: pointers and count go to 0.
  - Both may be set in one write.
- DATA write is ignored.
- `IO_Data` is 0 unless a DATA or STATUS read is active.

## Timing
- Reset (asynchronous): synchronisers, counters, `stable`, pending bits, pointers, count and `ovf` all go to 0. `IO_Data` = 0 and `irq` = 0. Reset mid-debounce or mid-queue discards everything.
- Read data is combinational from the current state in the access cycle. Pop, flush and clear take effect at the end of that cycle.
- Latency: a raw level that is held steady is accepted into `stable` DEBOUNCE_CYCLES+2 cycles after it first appears at the synchroniser input. It appears in the FIFO one cycle later.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no event.
- Simultaneous push and pop: both occur and count is unchanged. This is also valid when the FIFO is full.
- Flush in the same cycle as a push: flush wins. The pending bit is not cleared, so the event is pushed on the next cycle.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Count is separate and saturates neither way, by construction.
- With `IO_BTN_IRQ_EN`, `irq` is registered, equals `~empty` of the previous cycle, and resets to 0.

## Configuration
- `IO_BTN_IRQ_EN` defined: `irq` is driven as described in Timing, and STATUS[12] reads 1 as the IRQ-capability flag.
- `IO_BTN_IRQ_EN` undefined: `irq` is tied to 0 and STATUS[12] reads 0. No other behaviour changes.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and FIFO_DEPTH=4.
- Reset, then read STATUS → 32'h0000_0010 (empty only); read DATA → 32'h0.
- BTN[2] high for 10 cycles, then read DATA → 32'h8000_0006; read again → 32'h0. Then drop BTN[2], wait 10 cycles, read DATA → 32'h8000_0002.
- BTN[1] pulse lasting 3 cycles → no event; STATUS count = 0; `stable` = 0.
- BTN[3:0] rise together → FIFO holds 4,5,6,7 in that order; STATUS = full, count 4.
- With the FIFO full, release all 4 buttons, then press button 0 twice (each press debounced) with no reads → `ovf` = 1. Write STATUS with WD=32'hC0 → count 0, `ovf` 0. Pending releases 0..3 drain into the FIFO afterwards.
- `IO_BTN_IRQ_EN` build: one press → `irq` rises 1 cycle after the push; reading DATA drops `irq` 1 cycle after the pop. Assert `nrst` mid-debounce → `irq` = 0 and no event is queued.
